// File: rtl/single_port_ram_pkg.sv
// Shared constants and word type for the single-port RAM and its users.
package single_port_ram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 6;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/single_port_ram_if.sv
// Bundle of the RAM access signals; the master drives an access, the slave returns q.
interface single_port_ram_if
    import single_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] address;
    logic                  en;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] q;

    modport master (
        output data,
        output address,
        output en,
        output write_enable,
        input  q
    );

    modport slave (
        input  data,
        input  address,
        input  en,
        input  write_enable,
        output q
    );

endinterface

// File: rtl/single_port_ram.sv
// Single-port synchronous RAM with write-through, registered read data and
// an asynchronous reset that clears both the output register and every word.
module single_port_ram
    import single_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  en,
    input  logic                  write_enable,
    input  logic                  clk,
    output logic [DATA_WIDTH-1:0] q,
    input  logic                  rst_n
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is reset word by word because contents must read back as
    // zero after any reset; this forces flops instead of a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            if (write_enable) begin
                mem[address] <= data;
                q            <= data;
            end else begin
                q <= mem[address];
            end
        end
    end

endmodule

// File: tb/tb_single_port_ram.sv
// Directed bench for single_port_ram: an array model predicts q, a negedge
// process compares every cycle, and literal expectations pin the model.
module tb_single_port_ram;
    import single_port_ram_pkg::*;

    localparam int AW    = DEFAULT_ADDR_WIDTH;
    localparam int WORDS = 2**AW;

    logic clk;
    logic rst_n;

    single_port_ram_if bus ();

    single_port_ram dut (
        .data         (bus.data),
        .address      (bus.address),
        .en           (bus.en),
        .write_enable (bus.write_enable),
        .clk          (clk),
        .q            (bus.q),
        .rst_n        (rst_n)
    );

    word_t model_mem [WORDS];
    word_t exp_q;
    bit    cmp_on;
    int    vectors;
    int    miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input word_t actual, input word_t expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) check("q_vs_model", bus.q, exp_q);
    end

    task automatic model_clear();
        for (int i = 0; i < WORDS; i++) model_mem[i] = '0;
        exp_q = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input word_t d);
        @(negedge clk);
        bus.en = 1'b1; bus.write_enable = 1'b1; bus.address = a; bus.data = d;
        @(posedge clk); #1;
        if (rst_n) begin
            model_mem[a] = d;
            exp_q        = d;
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        @(negedge clk);
        bus.en = 1'b1; bus.write_enable = 1'b0; bus.address = a; bus.data = 'z;
        @(posedge clk); #1;
        if (rst_n) exp_q = model_mem[a];
    endtask

    task automatic do_idle(input logic [AW-1:0] a, input word_t d);
        @(negedge clk);
        bus.en = 1'b0; bus.write_enable = 1'b1; bus.address = a; bus.data = d;
        @(posedge clk); #1;
    endtask

    // Assert reset 3 time units after a rising edge so no clock edge coincides.
    task automatic pulse_reset_mid_cycle();
        @(posedge clk); #3;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("async_reset_q", bus.q, 8'h00);
        do_write(6'd16, 8'h77);
        check("write_blocked_in_reset", bus.q, 8'h00);
        do_read(6'd12);
        check("read_blocked_in_reset", bus.q, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors = 0; miscompares = 0; cmp_on = 1'b0;
        bus.en = 1'b0; bus.write_enable = 1'b0; bus.address = '0; bus.data = '0;
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_q", bus.q, 8'h00);
        cmp_on = 1'b1;

        do_read(6'd16);        check("read16_after_reset", bus.q, 8'h00);

        do_write(6'd16, 8'h18); check("wt_18", bus.q, 8'h18);
        do_write(6'd12, 8'h29); check("wt_29", bus.q, 8'h29);
        do_write(6'd7,  8'hAA); check("wt_AA", bus.q, 8'hAA);

        do_read(6'd16);        check("rd16", bus.q, 8'h18);
        do_read(6'd12);        check("rd12", bus.q, 8'h29);
        do_read(6'd7);         check("rd7",  bus.q, 8'hAA);

        do_idle(6'd16, 8'h55); check("en_low_hold", bus.q, 8'hAA);
        do_idle(6'd3,  8'h66); check("en_low_hold2", bus.q, 8'hAA);
        do_read(6'd16);        check("en_low_no_write", bus.q, 8'h18);

        do_write(6'd0,  8'h01); check("wt_min", bus.q, 8'h01);
        do_write(6'd63, 8'hFE); check("wt_max", bus.q, 8'hFE);
        do_read(6'd0);         check("rd_min", bus.q, 8'h01);
        do_read(6'd63);        check("rd_max", bus.q, 8'hFE);
        do_read(6'd1);         check("no_alias_1", bus.q, 8'h00);
        do_read(6'd62);        check("no_alias_62", bus.q, 8'h00);
        do_read(6'd16);        check("rd16_intact", bus.q, 8'h18);

        do_write(6'd12, 8'hC3);
        do_read(6'd12);        check("back_to_back", bus.q, 8'hC3);

        pulse_reset_mid_cycle();

        do_read(6'd16);        check("rd16_cleared", bus.q, 8'h00);
        do_read(6'd12);        check("rd12_cleared", bus.q, 8'h00);
        do_read(6'd7);         check("rd7_cleared",  bus.q, 8'h00);
        do_read(6'd63);        check("rd63_cleared", bus.q, 8'h00);

        do_write(6'd5, 8'h3C); check("post_reset_write", bus.q, 8'h3C);
        do_idle(6'd5, 8'h00);  check("post_reset_hold", bus.q, 8'h3C);
        do_read(6'd0);         check("rd0_cleared", bus.q, 8'h00);
        do_read(6'd5);         check("post_reset_read", bus.q, 8'h3C);

        @(negedge clk);
        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
